// File: rtl/ring_counter_pkg.sv
// Shared encodings and sizing helpers for the multimode ring counter.
// Included by ring_state_decode and multimode_ring_counter via import.
package ring_counter_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    // Width of the sequence index: a Johnson sequence has 2N states.
    function automatic int pos_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/ring_state_decode.sv
// Combinational decode of a ring/Johnson state into its sequence index and
// a legality flag for the currently selected mode.
module ring_state_decode
    import ring_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]              Q,
    input  logic                      mode,
    output logic [pos_width(N)-1:0]   pos,
    output logic                      legal
);

    localparam int PW = pos_width(N);
    // 2N may equal 2**PW; modular subtraction below still yields 2N - ones.
    localparam logic [PW-1:0] TWO_N = PW'(2 * N);

    logic [PW-1:0] ones;
    logic [PW-1:0] ring_pos;
    logic [PW-1:0] john_pos;
    logic [N-2:0]  edges;
    logic          ring_legal;
    logic          john_legal;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        ring_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (Q[i]) ring_pos = PW'(i);
        end

        ones  = PW'($countones(Q));
        edges = Q[N-1:1] ^ Q[N-2:0];

        ring_legal = $onehot(Q);
        john_legal = $onehot0(edges);

        // Filling phase counts ones upward; draining phase counts from 2N down.
        if (Q[0] || (Q == '0)) john_pos = ones;
        else                   john_pos = TWO_N - ones;

        if (mode == MODE_JOHNSON) begin
            pos   = john_pos;
            legal = john_legal;
        end else begin
            pos   = ring_legal ? ring_pos : '0;
            legal = ring_legal;
        end
    end

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with direction, load, wrap and illegal-state pulses.
// Define RING_SELF_CORRECT_EN to force illegal states back to the reset pattern.
module multimode_ring_counter
    import ring_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    mode,
    input  logic                    load,
    input  logic [N-1:0]            load_val,
    output logic [N-1:0]            Q,
    output logic [pos_width(N)-1:0] pos,
    output logic                    wrap,
    output logic                    err
);

    localparam int            PW      = pos_width(N);
    localparam logic [N-1:0]  RESET_Q = N'(1);

    if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_width
        $error("multimode_ring_counter: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
    end

    logic [N-1:0]  q_step;
    logic [PW-1:0] step_pos;
    logic [PW-1:0] seq_last;
    logic          legal;
    logic          step_legal;
    logic          wrap_hit;
    logic          fix;

    always_comb begin
        q_step = Q;
        if (mode == MODE_RING) begin
            if (dir == DIR_UP) q_step = {Q[N-2:0], Q[N-1]};
            else               q_step = {Q[0], Q[N-1:1]};
        end else begin
            if (dir == DIR_UP) q_step = {Q[N-2:0], ~Q[N-1]};
            else               q_step = {~Q[0], Q[N-1:1]};
        end
    end

    ring_state_decode #(.N(N)) u_cur_decode (
        .Q     (Q),
        .mode  (mode),
        .pos   (pos),
        .legal (legal)
    );

    ring_state_decode #(.N(N)) u_step_decode (
        .Q     (q_step),
        .mode  (mode),
        .pos   (step_pos),
        .legal (step_legal)
    );

    assign seq_last = (mode == MODE_JOHNSON) ? PW'(2 * N - 1) : PW'(N - 1);

    // A wrap is a crossing of the sequence boundary between two legal states.
    always_comb begin
        wrap_hit = 1'b0;
        if (legal && step_legal) begin
            if (dir == DIR_UP) wrap_hit = (pos == seq_last) && (step_pos == '0);
            else               wrap_hit = (pos == '0) && (step_pos == seq_last);
        end
    end

`ifdef RING_SELF_CORRECT_EN
    assign fix = ~legal;
`else
    assign fix = 1'b0;
`endif

    // NOTE: non-blocking assignments so all registers sample pre-edge values;
    // reset is asynchronous, so it appears in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q    <= RESET_Q;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                Q <= load_val;
            end else if (en) begin
                if (fix) begin
                    Q   <= RESET_Q;
                    err <= 1'b1;
                end else begin
                    Q    <= q_step;
                    wrap <= wrap_hit;
                end
            end
        end
    end

endmodule
